// File: rtl/ddr_pkg.sv
// ---------------------------------------------------------------------------
// ddr_pkg
// Shared HDR-DDR definitions for the receive frame tracker and the transmit
// side. It holds the preamble codes, the CRC word token, the receive FSM state
// encoding, and the parity function that both directions use.
// ---------------------------------------------------------------------------
package ddr_pkg;

    localparam logic [1:0] PRE_CMD   = 2'b01;
    localparam logic [1:0] PRE_DATA  = 2'b10;
    localparam logic [3:0] CRC_TOKEN = 4'hC;

    typedef enum logic [1:0] {
        DDR_IDLE = 2'd0,
        DDR_CMD  = 2'd1,
        DDR_DATA = 2'd2,
        DDR_DONE = 2'd3
    } ddr_state_e;

    // Returns {PA1, PA0}. PA1 covers the odd payload bits. PA0 covers the even
    // payload bits and is inverted, so an all-zero word never has zero parity.
    function automatic logic [1:0] ddr_parity(input logic [15:0] payload);
        logic pa1;
        logic pa0;
        pa1 = 1'b0;
        pa0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pa1 = pa1 ^ payload[2*i+1];
            pa0 = pa0 ^ payload[2*i];
        end
        return {pa1, pa0};
    endfunction

endpackage

// File: rtl/ddr_rx_frame_tracker_if.sv
// ---------------------------------------------------------------------------
// ddr_rx_frame_tracker_if
// Bundles the edge-detector inputs, the enable, the expected length and all
// decoded word and status outputs of the receive frame tracker.
//   slave  : the tracker side (it takes i_* and drives o_*)
//   master : the side that feeds the tracker and consumes its results
// ---------------------------------------------------------------------------
interface ddr_rx_frame_tracker_if #(
    parameter int LEN_W = 16
);
    logic             i_rxfc_en;
    logic             i_scl_pos_edge;
    logic             i_scl_neg_edge;
    logic             i_sda;
    logic [LEN_W-1:0] i_rxfc_data_len;
    logic [15:0]      o_rxfc_word;
    logic             o_rxfc_word_valid;
    logic             o_rxfc_is_cmd;
    logic             o_rxfc_last_frame;
    logic [4:0]       o_rxfc_crc;
    logic             o_rxfc_done;
    logic             o_rxfc_par_err;
    logic             o_rxfc_frame_err;

    modport slave (
        input  i_rxfc_en, i_scl_pos_edge, i_scl_neg_edge, i_sda, i_rxfc_data_len,
        output o_rxfc_word, o_rxfc_word_valid, o_rxfc_is_cmd, o_rxfc_last_frame,
               o_rxfc_crc, o_rxfc_done, o_rxfc_par_err, o_rxfc_frame_err
    );

    modport master (
        output i_rxfc_en, i_scl_pos_edge, i_scl_neg_edge, i_sda, i_rxfc_data_len,
        input  o_rxfc_word, o_rxfc_word_valid, o_rxfc_is_cmd, o_rxfc_last_frame,
               o_rxfc_crc, o_rxfc_done, o_rxfc_par_err, o_rxfc_frame_err
    );
endinterface

// File: rtl/ddr_word_deser.sv
// ---------------------------------------------------------------------------
// ddr_word_deser
// Shifts one SDA bit per sample, MSB first, and flags the sample that
// completes a WORD_BITS-bit word.
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_en          : low clears the bit counter and the shift register
//   i_sample      : one SCL edge was seen this cycle
//   i_sda         : SDA level for this sample
//   o_word        : the full word as it will be on the completing sample
//   o_word_done   : high during the cycle of the completing sample
// ---------------------------------------------------------------------------
module ddr_word_deser #(
    parameter int WORD_BITS = 20
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_sample,
    input  logic                 i_sda,
    output logic [WORD_BITS-1:0] o_word,
    output logic                 o_word_done
);

    localparam logic [4:0] LAST_BIT = 5'(WORD_BITS - 1);

    // Only the earlier WORD_BITS-1 bits are stored. The final bit arrives live
    // with the completing sample, so the word is available in that cycle.
    logic [WORD_BITS-2:0] r_shift;
    logic [4:0]           r_bit_cnt;
    logic                 w_last_bit;

    assign w_last_bit  = (r_bit_cnt == LAST_BIT);
    assign o_word      = {r_shift, i_sda};
    assign o_word_done = i_sample & w_last_bit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (!i_en) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (i_sample) begin
            r_shift   <= {r_shift[WORD_BITS-3:0], i_sda};
            r_bit_cnt <= w_last_bit ? 5'd0 : r_bit_cnt + 5'd1;
        end
    end

endmodule

// File: rtl/ddr_rx_frame_tracker.sv
// ---------------------------------------------------------------------------
// ddr_rx_frame_tracker
// Target-side HDR-DDR receive tracker. It deserializes words sampled on both
// SCL edges and classifies each one as a command, data or CRC word. It checks
// parity, counts data words against the expected length, and flags the last
// frame as well as early or late termination.
//   i_rxfc_clk, i_rxfc_rst : clock, asynchronous active-high reset
//   bus (slave)            : enable, edge strobes, SDA, expected length in;
//                            word, word_valid, is_cmd, last_frame, crc, done,
//                            par_err, frame_err out
// ---------------------------------------------------------------------------
module ddr_rx_frame_tracker
    import ddr_pkg::*;
#(
    parameter int WORD_BITS = 20,
    parameter int LEN_W     = 16
) (
    input  logic                   i_rxfc_clk,
    input  logic                   i_rxfc_rst,
    ddr_rx_frame_tracker_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = DDR_IDLE;
    localparam logic [1:0] ST_CMD  = DDR_CMD;
    localparam logic [1:0] ST_DATA = DDR_DATA;
    localparam logic [1:0] ST_DONE = DDR_DONE;

    logic [1:0]           r_state;
    logic [LEN_W-1:0]     r_remain;
    logic [15:0]          r_word;
    logic                 r_word_valid;
    logic                 r_is_cmd;
    logic                 r_last_frame;
    logic [4:0]           r_crc;
    logic                 r_done;
    logic                 r_par_err;
    logic                 r_frame_err;

    logic                 w_sample;
    logic [WORD_BITS-1:0] w_word;
    logic                 w_word_done;
    logic [1:0]           w_pre;
    logic [15:0]          w_payload;
    logic [1:0]           w_par;
    logic                 w_par_bad;
    logic                 w_is_crc;

    // Both strobes in the same cycle still count as a single sample.
    assign w_sample = bus.i_rxfc_en & (bus.i_scl_pos_edge | bus.i_scl_neg_edge);

    ddr_word_deser #(.WORD_BITS(WORD_BITS)) u_deser (
        .i_clk       (i_rxfc_clk),
        .i_rst       (i_rxfc_rst),
        .i_en        (bus.i_rxfc_en),
        .i_sample    (w_sample),
        .i_sda       (bus.i_sda),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    assign w_pre     = w_word[WORD_BITS-1:WORD_BITS-2];
    assign w_payload = w_word[WORD_BITS-3:2];
    assign w_par     = w_word[1:0];
    assign w_par_bad = (w_par != ddr_parity(w_payload));
    assign w_is_crc  = (w_pre == PRE_CMD) && (w_payload[15:12] == CRC_TOKEN);

    // The FSM plus the output registers. Pulse outputs default low each cycle,
    // so every flag lasts exactly one clock after the completing sample.
    always_ff @(posedge i_rxfc_clk or posedge i_rxfc_rst) begin
        if (i_rxfc_rst) begin
            r_state      <= ST_IDLE;
            r_remain     <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_is_cmd     <= 1'b0;
            r_last_frame <= 1'b0;
            r_crc        <= '0;
            r_done       <= 1'b0;
            r_par_err    <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            r_is_cmd     <= 1'b0;
            r_done       <= 1'b0;
            r_par_err    <= 1'b0;
            r_frame_err  <= 1'b0;
            if (!bus.i_rxfc_en) begin
                r_state      <= ST_IDLE;
                r_remain     <= '0;
                r_last_frame <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_sample) r_state <= ST_CMD;
                    end
                    ST_CMD: begin
                        if (w_word_done) begin
                            if (w_pre == PRE_CMD) begin
                                r_word       <= w_payload;
                                r_word_valid <= 1'b1;
                                r_is_cmd     <= 1'b1;
                                r_par_err    <= w_par_bad;
                                r_remain     <= bus.i_rxfc_data_len;
                                r_last_frame <= (bus.i_rxfc_data_len == '0);
                                r_state      <= ST_DATA;
                            end else begin
                                r_frame_err  <= 1'b1;
                                r_state      <= ST_IDLE;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_word_done) begin
                            if (w_is_crc) begin
                                // Terminating with data words still owed
                                // counts as early termination.
                                r_crc        <= w_payload[11:7];
                                r_done       <= 1'b1;
                                r_frame_err  <= (r_remain != '0);
                                r_last_frame <= 1'b0;
                                r_state      <= ST_DONE;
                            end else if (w_pre == PRE_DATA && r_remain != '0) begin
                                r_word       <= w_payload;
                                r_word_valid <= 1'b1;
                                r_par_err    <= w_par_bad;
                                r_remain     <= r_remain - 1'b1;
                                r_last_frame <= (r_remain == LEN_W'(1));
                            end else begin
                                // Overrun data, or a preamble that is not valid
                                // here. The word is dropped.
                                r_frame_err  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_DONE;
                    end
                endcase
            end
        end
    end

    assign bus.o_rxfc_word       = r_word;
    assign bus.o_rxfc_word_valid = r_word_valid;
    assign bus.o_rxfc_is_cmd     = r_is_cmd;
    assign bus.o_rxfc_last_frame = r_last_frame;
    assign bus.o_rxfc_crc        = r_crc;
    assign bus.o_rxfc_done       = r_done;
    assign bus.o_rxfc_par_err    = r_par_err;
    assign bus.o_rxfc_frame_err  = r_frame_err;

endmodule

// File: tb/tb_ddr_rx_frame_tracker.sv
// ---------------------------------------------------------------------------
// tb_ddr_rx_frame_tracker
// Directed bench for the HDR-DDR receive frame tracker. It drives words bit by
// bit on alternating SCL strobes and compares the decoded outputs against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_ddr_rx_frame_tracker;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    ddr_rx_frame_tracker_if #(.LEN_W(16)) bus ();

    ddr_rx_frame_tracker dut (
        .i_rxfc_clk (clk),
        .i_rxfc_rst (rst),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    // Payload parities below were worked out by hand:
    //   0x8F12 -> 00, 0xA5A5 -> 01, 0x0001 -> 00, 0xFFFF -> 01
    function automatic logic [19:0] mk(input logic [1:0] pre, input logic [15:0] pl,
                                       input logic [1:0] par);
        return {pre, pl, par};
    endfunction

    function automatic logic [19:0] mk_crc(input logic [4:0] crc);
        return {2'b01, 4'hC, crc, 7'h00, 2'b00};
    endfunction

    // Drives the first n bits of w, MSB first, one sample per clock. The
    // strobes alternate between edges, and the final bit of a full word raises
    // both strobes at once. The task returns on the negedge after the last
    // sample, when the registered results are visible.
    task automatic send_bits(input logic [19:0] w, input int n);
        for (int i = 19; i > 19 - n; i--) begin
            @(negedge clk);
            bus.i_sda          = w[i];
            bus.i_scl_pos_edge = (i == 0) ? 1'b1 : i[0];
            bus.i_scl_neg_edge = (i == 0) ? 1'b1 : ~i[0];
        end
        @(negedge clk);
        bus.i_scl_pos_edge = 1'b0;
        bus.i_scl_neg_edge = 1'b0;
    endtask

    task automatic restart();
        @(negedge clk);
        bus.i_rxfc_en = 1'b0;
        @(negedge clk);
        bus.i_rxfc_en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_rxfc_en = 1'b0;
        bus.i_scl_pos_edge = 1'b0;
        bus.i_scl_neg_edge = 1'b0;
        bus.i_sda = 1'b0;
        bus.i_rxfc_data_len = '0;
        repeat (3) @(negedge clk);
        total++; if (bus.o_rxfc_word !== 16'h0) $display("[TB] FAIL reset_word got %h want 0", bus.o_rxfc_word); else passed++;
        total++; if (bus.o_rxfc_word_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", bus.o_rxfc_word_valid); else passed++;
        total++; if (bus.o_rxfc_last_frame !== 1'b0) $display("[TB] FAIL reset_last got %b want 0", bus.o_rxfc_last_frame); else passed++;
        total++; if (bus.o_rxfc_crc !== 5'h0) $display("[TB] FAIL reset_crc got %h want 0", bus.o_rxfc_crc); else passed++;
        total++; if ({bus.o_rxfc_done, bus.o_rxfc_par_err, bus.o_rxfc_frame_err, bus.o_rxfc_is_cmd} !== 4'b0)
            $display("[TB] FAIL reset_flags got %b want 0000", {bus.o_rxfc_done, bus.o_rxfc_par_err, bus.o_rxfc_frame_err, bus.o_rxfc_is_cmd}); else passed++;
        rst = 1'b0;
        @(negedge clk);
        bus.i_rxfc_en = 1'b1;
    endtask

    task automatic test_normal();
        restart();
        bus.i_rxfc_data_len = 16'd2;
        send_bits(mk(2'b01, 16'h8F12, 2'b00), 20);
        total++; if ({bus.o_rxfc_word_valid, bus.o_rxfc_is_cmd} !== 2'b11) $display("[TB] FAIL norm_cmd_valid got %b want 11", {bus.o_rxfc_word_valid, bus.o_rxfc_is_cmd}); else passed++;
        total++; if (bus.o_rxfc_word !== 16'h8F12) $display("[TB] FAIL norm_cmd_word got %h want 8f12", bus.o_rxfc_word); else passed++;
        total++; if ({bus.o_rxfc_last_frame, bus.o_rxfc_par_err, bus.o_rxfc_frame_err} !== 3'b000) $display("[TB] FAIL norm_cmd_flags got %b want 000", {bus.o_rxfc_last_frame, bus.o_rxfc_par_err, bus.o_rxfc_frame_err}); else passed++;
        send_bits(mk(2'b10, 16'hA5A5, 2'b01), 20);
        total++; if ({bus.o_rxfc_word_valid, bus.o_rxfc_is_cmd} !== 2'b10) $display("[TB] FAIL norm_d1_valid got %b want 10", {bus.o_rxfc_word_valid, bus.o_rxfc_is_cmd}); else passed++;
        total++; if (bus.o_rxfc_word !== 16'hA5A5) $display("[TB] FAIL norm_d1_word got %h want a5a5", bus.o_rxfc_word); else passed++;
        total++; if ({bus.o_rxfc_last_frame, bus.o_rxfc_par_err, bus.o_rxfc_frame_err} !== 3'b000) $display("[TB] FAIL norm_d1_flags got %b want 000", {bus.o_rxfc_last_frame, bus.o_rxfc_par_err, bus.o_rxfc_frame_err}); else passed++;
        send_bits(mk(2'b10, 16'h0001, 2'b00), 20);
        total++; if ({bus.o_rxfc_word_valid, bus.o_rxfc_is_cmd} !== 2'b10) $display("[TB] FAIL norm_d2_valid got %b want 10", {bus.o_rxfc_word_valid, bus.o_rxfc_is_cmd}); else passed++;
        total++; if (bus.o_rxfc_word !== 16'h0001) $display("[TB] FAIL norm_d2_word got %h want 0001", bus.o_rxfc_word); else passed++;
        total++; if ({bus.o_rxfc_last_frame, bus.o_rxfc_par_err, bus.o_rxfc_frame_err} !== 3'b100) $display("[TB] FAIL norm_d2_flags got %b want 100", {bus.o_rxfc_last_frame, bus.o_rxfc_par_err, bus.o_rxfc_frame_err}); else passed++;
        send_bits(mk_crc(5'h15), 20);
        total++; if ({bus.o_rxfc_done, bus.o_rxfc_word_valid, bus.o_rxfc_frame_err, bus.o_rxfc_last_frame} !== 4'b1000)
            $display("[TB] FAIL norm_crc_flags got %b want 1000", {bus.o_rxfc_done, bus.o_rxfc_word_valid, bus.o_rxfc_frame_err, bus.o_rxfc_last_frame}); else passed++;
        total++; if (bus.o_rxfc_crc !== 5'h15) $display("[TB] FAIL norm_crc_value got %h want 15", bus.o_rxfc_crc); else passed++;
        @(negedge clk);
        total++; if (bus.o_rxfc_done !== 1'b0) $display("[TB] FAIL norm_done_pulse got %b want 0", bus.o_rxfc_done); else passed++;
        // Samples seen in DONE must not produce any output.
        send_bits(mk(2'b01, 16'h8F12, 2'b00), 20);
        total++; if ({bus.o_rxfc_word_valid, bus.o_rxfc_frame_err} !== 2'b00) $display("[TB] FAIL norm_done_ignore got %b want 00", {bus.o_rxfc_word_valid, bus.o_rxfc_frame_err}); else passed++;
    endtask

    task automatic test_zero_length();
        restart();
        bus.i_rxfc_data_len = 16'd0;
        send_bits(mk(2'b01, 16'h8F12, 2'b00), 20);
        total++; if ({bus.o_rxfc_word_valid, bus.o_rxfc_is_cmd, bus.o_rxfc_last_frame} !== 3'b111) $display("[TB] FAIL zero_cmd got %b want 111", {bus.o_rxfc_word_valid, bus.o_rxfc_is_cmd, bus.o_rxfc_last_frame}); else passed++;
        send_bits(mk_crc(5'h0A), 20);
        total++; if ({bus.o_rxfc_done, bus.o_rxfc_frame_err, bus.o_rxfc_last_frame} !== 3'b100) $display("[TB] FAIL zero_crc got %b want 100", {bus.o_rxfc_done, bus.o_rxfc_frame_err, bus.o_rxfc_last_frame}); else passed++;
        total++; if (bus.o_rxfc_crc !== 5'h0A) $display("[TB] FAIL zero_crc_value got %h want 0a", bus.o_rxfc_crc); else passed++;
    endtask

    task automatic test_parity_error();
        restart();
        bus.i_rxfc_data_len = 16'd1;
        send_bits(mk(2'b01, 16'h8F12, 2'b00), 20);
        total++; if (bus.o_rxfc_par_err !== 1'b0) $display("[TB] FAIL par_cmd got %b want 0", bus.o_rxfc_par_err); else passed++;
        send_bits(mk(2'b10, 16'hFFFF, 2'b00), 20);
        total++; if ({bus.o_rxfc_par_err, bus.o_rxfc_word_valid, bus.o_rxfc_last_frame} !== 3'b111) $display("[TB] FAIL par_data got %b want 111", {bus.o_rxfc_par_err, bus.o_rxfc_word_valid, bus.o_rxfc_last_frame}); else passed++;
        total++; if (bus.o_rxfc_word !== 16'hFFFF) $display("[TB] FAIL par_word got %h want ffff", bus.o_rxfc_word); else passed++;
        send_bits(mk_crc(5'h03), 20);
        total++; if ({bus.o_rxfc_done, bus.o_rxfc_frame_err} !== 2'b10) $display("[TB] FAIL par_crc got %b want 10", {bus.o_rxfc_done, bus.o_rxfc_frame_err}); else passed++;
    endtask

    task automatic test_early_term();
        restart();
        bus.i_rxfc_data_len = 16'd3;
        send_bits(mk(2'b01, 16'h8F12, 2'b00), 20);
        total++; if (bus.o_rxfc_last_frame !== 1'b0) $display("[TB] FAIL early_cmd_last got %b want 0", bus.o_rxfc_last_frame); else passed++;
        send_bits(mk(2'b10, 16'hA5A5, 2'b01), 20);
        total++; if ({bus.o_rxfc_word_valid, bus.o_rxfc_last_frame} !== 2'b10) $display("[TB] FAIL early_data got %b want 10", {bus.o_rxfc_word_valid, bus.o_rxfc_last_frame}); else passed++;
        send_bits(mk_crc(5'h1F), 20);
        total++; if ({bus.o_rxfc_done, bus.o_rxfc_frame_err, bus.o_rxfc_last_frame} !== 3'b110) $display("[TB] FAIL early_crc got %b want 110", {bus.o_rxfc_done, bus.o_rxfc_frame_err, bus.o_rxfc_last_frame}); else passed++;
        total++; if (bus.o_rxfc_crc !== 5'h1F) $display("[TB] FAIL early_crc_value got %h want 1f", bus.o_rxfc_crc); else passed++;
    endtask

    task automatic test_overrun();
        restart();
        bus.i_rxfc_data_len = 16'd1;
        send_bits(mk(2'b01, 16'h8F12, 2'b00), 20);
        send_bits(mk(2'b10, 16'hA5A5, 2'b01), 20);
        total++; if ({bus.o_rxfc_word_valid, bus.o_rxfc_last_frame, bus.o_rxfc_frame_err} !== 3'b110) $display("[TB] FAIL over_d1 got %b want 110", {bus.o_rxfc_word_valid, bus.o_rxfc_last_frame, bus.o_rxfc_frame_err}); else passed++;
        send_bits(mk(2'b10, 16'h0001, 2'b00), 20);
        total++; if ({bus.o_rxfc_word_valid, bus.o_rxfc_frame_err} !== 2'b01) $display("[TB] FAIL over_d2 got %b want 01", {bus.o_rxfc_word_valid, bus.o_rxfc_frame_err}); else passed++;
        total++; if (bus.o_rxfc_word !== 16'hA5A5) $display("[TB] FAIL over_word_kept got %h want a5a5", bus.o_rxfc_word); else passed++;
        send_bits(mk(2'b11, 16'h1234, 2'b00), 20);
        total++; if ({bus.o_rxfc_word_valid, bus.o_rxfc_frame_err, bus.o_rxfc_done} !== 3'b010) $display("[TB] FAIL over_pre11 got %b want 010", {bus.o_rxfc_word_valid, bus.o_rxfc_frame_err, bus.o_rxfc_done}); else passed++;
    endtask

    task automatic test_abort();
        restart();
        bus.i_rxfc_data_len = 16'd0;
        send_bits(mk(2'b01, 16'h8F12, 2'b00), 20);
        total++; if (bus.o_rxfc_last_frame !== 1'b1) $display("[TB] FAIL abort_pre_last got %b want 1", bus.o_rxfc_last_frame); else passed++;
        send_bits(mk(2'b10, 16'h1234, 2'b01), 10);
        bus.i_rxfc_en = 1'b0;
        @(negedge clk);
        total++; if (bus.o_rxfc_last_frame !== 1'b0) $display("[TB] FAIL abort_last_clear got %b want 0", bus.o_rxfc_last_frame); else passed++;
        bus.i_rxfc_en = 1'b1;
        bus.i_rxfc_data_len = 16'd5;
        send_bits(mk(2'b01, 16'h8F12, 2'b00), 20);
        total++; if ({bus.o_rxfc_word_valid, bus.o_rxfc_is_cmd, bus.o_rxfc_frame_err, bus.o_rxfc_last_frame} !== 4'b1100)
            $display("[TB] FAIL abort_cmd got %b want 1100", {bus.o_rxfc_word_valid, bus.o_rxfc_is_cmd, bus.o_rxfc_frame_err, bus.o_rxfc_last_frame}); else passed++;
        total++; if (bus.o_rxfc_word !== 16'h8F12) $display("[TB] FAIL abort_word got %h want 8f12", bus.o_rxfc_word); else passed++;
    endtask

    task automatic test_reset_mid_word();
        restart();
        bus.i_rxfc_data_len = 16'd0;
        send_bits(mk(2'b01, 16'h8F12, 2'b00), 20);
        send_bits(mk(2'b10, 16'hFFFF, 2'b01), 7);
        rst = 1'b1;
        #1;
        total++; if (bus.o_rxfc_word !== 16'h0) $display("[TB] FAIL rst_mid_word got %h want 0", bus.o_rxfc_word); else passed++;
        total++; if ({bus.o_rxfc_last_frame, bus.o_rxfc_crc} !== 6'h0) $display("[TB] FAIL rst_mid_last_crc got %h want 0", {bus.o_rxfc_last_frame, bus.o_rxfc_crc}); else passed++;
        @(negedge clk);
        rst = 1'b0;
        bus.i_rxfc_data_len = 16'd2;
        send_bits(mk(2'b01, 16'h8F12, 2'b00), 20);
        total++; if ({bus.o_rxfc_word_valid, bus.o_rxfc_is_cmd, bus.o_rxfc_frame_err} !== 3'b110) $display("[TB] FAIL rst_mid_recover got %b want 110", {bus.o_rxfc_word_valid, bus.o_rxfc_is_cmd, bus.o_rxfc_frame_err}); else passed++;
        total++; if (bus.o_rxfc_word !== 16'h8F12) $display("[TB] FAIL rst_mid_recover_word got %h want 8f12", bus.o_rxfc_word); else passed++;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero_length();
        test_parity_error();
        test_early_term();
        test_overrun();
        test_abort();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ddr_rx_frame_tracker.md
# ddr_rx_frame_tracker

Target-side counterpart of the controller CCC frame counter. Deserializes the HDR-DDR SDA stream sampled on both SCL edges into 20-bit words, classifies each word as command, data or CRC, and checks its parity. It counts received data words against the expected length and flags the last frame and early or late termination. It sits between the target SDA/SCL edge detectors and the target CCC/data handler.

## Interface
Parameters:
- `WORD_BITS`, default 20: bits per DDR word (2 preamble + 16 payload + 2 parity).
- `LEN_W`, default 16: width of the expected data-word count.

Ports:
- `i_rxfc_clk`  in  1: system clock.
- `i_rxfc_rst`  in  1: reset, asynchronous, active-high. All state and outputs clear.
- `i_rxfc_en`  in  1: block enable. Low means synchronous clear to IDLE.
- `i_scl_pos_edge`  in  1: single-cycle SCL rising-edge strobe.
- `i_scl_neg_edge`  in  1: single-cycle SCL falling-edge strobe.
- `i_sda`  in  1: synchronized SDA level.
- `i_rxfc_data_len`  in  LEN_W: expected data words. Sampled when the command word completes.
- `o_rxfc_word`  out  16: payload of the last completed word (bits 17:2). Reset 0.
- `o_rxfc_word_valid`  out  1: one-cycle pulse per completed cmd/data word. Reset 0.
- `o_rxfc_is_cmd`  out  1: qualifies `word_valid`. 1 means command word. Reset 0.
- `o_rxfc_last_frame`  out  1: level. Remaining data words = 0 and a CRC word is expected. Reset 0.
- `o_rxfc_crc`  out  5: CRC5 field of the received CRC word. Reset 0.
- `o_rxfc_done`  out  1: one-cycle pulse when a CRC word is accepted. Reset 0.
- `o_rxfc_par_err`  out  1: one-cycle pulse on a parity mismatch. Reset 0.
- `o_rxfc_frame_err`  out  1: one-cycle pulse on a preamble or sequence violation. Reset 0.

## Operation
- **Sampling.** A sample occurs when `en` is high and (`pos_edge` or `neg_edge`) is high. If both strobes are high in one cycle, that counts as one sample.
- **Shift register.** Each sample shifts `i_sda` into a 20-bit register, MSB first. A 5-bit bit counter runs 0..19. At the sample where the counter = 19, the word is complete and the counter wraps to 0.
- **Word fields.** w[19:18] is the preamble, w[17:2] the payload, w[1:0] the parity bits PA1/PA0.
- **Parity.** PA1 = XOR of payload bits 15,13,…,1. PA0 = (XOR of payload bits 14,12,…,0) ^ 1. Any mismatch produces a `par_err` pulse, and the word is still delivered.
- **CRC word.** Preamble 01 with payload[15:12] = 4'hC. The CRC5 field is payload[11:7]. Parity is not checked on the CRC word.
- **FSM states:** IDLE, CMD, DATA, DONE.
  - IDLE: moves to CMD on the first sample.
  - CMD: word complete with preamble 01 → load `remain = i_rxfc_data_len`, pulse `word_valid` with `is_cmd` = 1, go to DATA. If `remain` loads 0, `last_frame` = 1 immediately. Any other preamble → `frame_err`, return to IDLE.
  - DATA, preamble 10 with `remain` > 0: pulse `word_valid`, `remain` −1. Reaching 0 sets `last_frame`.
  - DATA, preamble 10 with `remain` = 0: `frame_err`, word dropped, stay in DATA.
  - DATA, CRC word: latch `o_rxfc_crc`, pulse `done`, clear `last_frame`, go to DONE. If `remain` > 0, also pulse `frame_err` (early termination).
  - DATA, preamble 00 or 11: `frame_err`, stay in DATA.
  - DONE: further samples are ignored until `en` goes low.
- **Disable.** `en` low in any state (including mid-word) clears the bit counter, the shift register, `remain` and `last_frame`, and returns the FSM to IDLE. Pulse outputs stay 0.
- **Arithmetic.** `remain` is LEN_W bits, decrements only when > 0, and never wraps.

## Timing
- Word-complete outputs (`word`, `word_valid`, `is_cmd`, `par_err`, `frame_err`, `crc`, `done`) are registered and appear 1 clock after the completing sample.
- `last_frame` updates in the same cycle as the corresponding `word_valid`.
- Reset asserted mid-word: outputs clear asynchronously. After release the block restarts in IDLE with bit counter 0.
- Back-to-back words need no gap cycles. The minimum sample spacing is 1 clock.

## Structure
- Shared package `ddr_pkg` holds:
  - preamble constants `PRE_CMD` = 2'b01 and `PRE_DATA` = 2'b10;
  - `CRC_TOKEN` = 4'hC;
  - the FSM state enum;
  - function `ddr_parity(payload[15:0])` returning {PA1, PA0}, also reused by the transmit side.
- One natural sub-module, `ddr_word_deser`: the shift register, bit counter and word-complete strobe. The FSM, counting and checks stay in the top module.

## Test plan
- **Normal transfer.** `data_len` = 2; send cmd 0x8F12, data 0xA5A5, data 0x0001 (all correct parity), then a CRC word with CRC = 5'h15. Expect 3 `word_valid` pulses with `is_cmd` = 1,0,0. `last_frame` rises with the 3rd pulse. `done` pulses 1 clk after the CRC word with `crc` = 0x15. No errors.
- **Zero length.** `data_len` = 0; send cmd then CRC. Expect `last_frame` = 1 together with the cmd `word_valid`, then a `done` pulse and no `frame_err`.
- **Parity error.** Send data 0xFFFF with PA0 flipped. Expect a `par_err` pulse, `word_valid` still pulses, and `remain` still decrements.
- **Early termination.** `data_len` = 3; send cmd, 1 data word, then CRC. Expect `frame_err` and `done` pulses in the same cycle, and `last_frame` stays 0.
- **Overrun and bad preamble.** `data_len` = 1; send cmd, 2 data words, then one word with preamble 11. Expect `frame_err` on the 2nd data word (no `word_valid`) and again on the preamble-11 word.
- **Abort.** Drop `en` after sample 9 of a data word, re-enable, and send a full cmd. Expect a clean cmd decode. Separately, assert `i_rxfc_rst` mid-word and expect every output at 0 in the same cycle.
